// File: rtl/rv_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide,
// XLEN iterations plus one sign-fix cycle, single-cycle done pulse.
module rv_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic              r_neg;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_rem;

  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_neg;
  logic [XLEN:0]     w_msum;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_q;
  logic [XLEN-1:0]   w_r;
  logic [XLEN-1:0]   w_res;

  // Operand magnitudes and final result sign, evaluated at issue
  always_comb begin
    w_a_signed = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                 (funct3 == F_DIV)  || (funct3 == F_REM);
    w_b_signed = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
    w_a_neg    = w_a_signed & op_a[XLEN-1];
    w_b_neg    = w_b_signed & op_b[XLEN-1];
    w_a_mag    = w_a_neg ? XLEN'(-op_a) : op_a;
    w_b_mag    = w_b_neg ? XLEN'(-op_b) : op_b;
    if (!funct3[2]) begin
      w_neg = w_a_neg ^ w_b_neg;
    end else if (funct3[1]) begin
      w_neg = w_a_neg;
    end else begin
      // Divide by zero must yield all ones regardless of operand signs
      w_neg = (w_a_neg ^ w_b_neg) & (op_b != '0);
    end
  end

  // One multiply step and one restoring-divide step per CALC cycle
  always_comb begin
    w_msum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
    w_shift = {r_rem, r_quo[XLEN-1]};
    w_diff  = w_shift - {1'b0, r_b};
  end

  // Sign correction and result selection for the FIN cycle
  always_comb begin
    w_prod = r_neg ? (2*XLEN)'(-r_acc) : r_acc;
    w_q    = r_neg ? XLEN'(-r_quo) : r_quo;
    w_r    = r_neg ? XLEN'(-r_rem) : r_rem;
    case (r_op)
      F_MUL:        w_res = w_prod[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:       w_res = w_prod[2*XLEN-1:XLEN];
      3'b100,
      3'b101:       w_res = w_q;
      default:      w_res = w_r;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_neg   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= funct3;
            r_neg   <= w_neg;
            r_a     <= w_a_mag;
            r_b     <= w_b_mag;
            r_acc   <= {{XLEN{1'b0}}, w_b_mag};
            r_quo   <= w_a_mag;
            r_rem   <= '0;
            r_cnt   <= CW'(XLEN);
            busy    <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (r_op[2]) begin
            r_rem <= w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
          end else begin
            r_acc <= {w_msum, r_acc[XLEN-1:1]};
          end
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          result  <= w_res;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_muldiv.sv
// Directed scoreboard bench for rv_muldiv: results, latency, handshake and reset abort.
module tb_rv_muldiv;

  localparam int unsigned XLEN = 32;
  localparam int LAT = 33;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;
  logic [XLEN-1:0] last_exp;
  string           last_tag;

  logic [XLEN-1:0] sb_q[$];
  string           sb_tag[$];

  rv_muldiv #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a request now; it is accepted at the next rising edge
  task automatic do_start(input logic [2:0] f, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp,
                          input string tag);
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    sb_q.push_back(exp);
    sb_tag.push_back(tag);
    @(posedge clk);
    #1;
    start = 1'b0;
    t0    = cyc;
    check({tag, "_busy"}, XLEN'(busy), XLEN'(1));
  endtask

  // Wait (bounded) for done, then score result and latency; returns in the done cycle
  task automatic wait_done();
    while (!done && (cyc - t0) < 100) begin
      @(posedge clk);
      #1;
    end
    last_exp = sb_q.pop_front();
    last_tag = sb_tag.pop_front();
    if (!done) begin
      checks++;
      failures++;
      $error("FAIL %s_timeout observed=no_done expected=done", last_tag);
    end else begin
      check(last_tag, result, last_exp);
      check({last_tag, "_lat"}, XLEN'(cyc - t0), XLEN'(LAT));
      check({last_tag, "_busy_done"}, XLEN'(busy), XLEN'(0));
    end
  endtask

  // done must drop after one cycle while result holds
  task automatic settle();
    @(posedge clk);
    #1;
    check({last_tag, "_pulse"}, XLEN'(done), XLEN'(0));
    check({last_tag, "_hold"}, result, last_exp);
  endtask

  task automatic run(input logic [2:0] f, input logic [XLEN-1:0] a,
                     input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp,
                     input string tag);
    @(negedge clk);
    do_start(f, a, b, exp, tag);
    wait_done();
    settle();
  endtask

  task automatic quiet(input string tag, input int n);
    int nd;
    nd = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    check(tag, XLEN'(nd), XLEN'(0));
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    funct3 = 3'd0;
    op_a   = '0;
    op_b   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", XLEN'(busy), XLEN'(0));
    check("rst_done", XLEN'(done), XLEN'(0));
    check("rst_result", result, '0);
    @(negedge clk);
    rst = 1'b0;

    run(3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
    run(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh");
    run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
    run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    run(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div");
    run(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem");
    run(3'b101, 32'd100,       32'd7,         32'd14,        "divu");
    run(3'b111, 32'd100,       32'd7,         32'd2,         "remu");
    run(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, "divu_by0");
    run(3'b111, 32'd5,         32'd0,         32'd5,         "remu_by0");
    run(3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, "div_by0");
    run(3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, "rem_by0");
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_ovf");

    // Inputs and a stray start while busy must be ignored
    @(negedge clk);
    do_start(3'b101, 32'd100, 32'd7, 32'd14, "busy_ignore");
    repeat (10) @(posedge clk);
    @(negedge clk);
    op_a   = $urandom;
    op_b   = 32'd0;
    funct3 = 3'b000;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    op_a   = $urandom;
    wait_done();
    settle();
    quiet("no_extra_done", 40);

    // Back-to-back: second request issued in the done cycle
    @(negedge clk);
    do_start(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "b2b_first");
    wait_done();
    do_start(3'b111, 32'd100, 32'd7, 32'd2, "b2b_second");
    wait_done();
    settle();

    // Reset mid-divide aborts without a done pulse
    @(negedge clk);
    do_start(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "abort");
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", XLEN'(busy), XLEN'(0));
    check("abort_done", XLEN'(done), XLEN'(0));
    check("abort_result", result, '0);
    sb_q.delete();
    sb_tag.delete();
    @(negedge clk);
    rst = 1'b0;
    quiet("abort_no_done", 40);
    run(3'b000, 32'd3, 32'd4, 32'd12, "mul_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
